// File: rtl/apresentador_sequencia_pkg.sv
// Shared game definitions: the sequence presenter state codes and the
// default display timings reused by the game FSM.
package jogo_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        BUSCA   = 3'd1,
        CARREGA = 3'd2,
        ACESO   = 3'd3,
        APAGADO = 3'd4,
        FIM     = 3'd5
    } estado_apresentador_t;

    localparam int unsigned T_ACESO_PADRAO   = 500;
    localparam int unsigned T_APAGADO_PADRAO = 250;

    // Counter width able to hold the larger reload value (parameter minus 1).
    function automatic int unsigned largura_temporizador(input int unsigned a,
                                                         input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        if (m <= 1) begin
            return 1;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/apresentador_sequencia_if.sv
// Link between the game FSM / ROM mux side (master) and the presenter (slave).
interface apresentador_sequencia_if;

    logic       iniciar;
    logic       abortar;
    logic [3:0] limite;
    logic [6:0] dado;
    logic [3:0] endereco;
    logic [6:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    modport master (
        output iniciar, abortar, limite, dado,
        input  endereco, leds, ocupado, pronto, db_estado
    );

    modport slave (
        input  iniciar, abortar, limite, dado,
        output endereco, leds, ocupado, pronto, db_estado
    );

endinterface

// File: rtl/apresentador_sequencia_temporizador_carga.sv
// Down-counter with synchronous load and enable; stops at zero and flags it.
module temporizador_carga #(
    parameter int unsigned LARGURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_carga,
    input  logic [LARGURA-1:0] i_valor,
    input  logic               i_habilita,
    output logic               o_zero
);

    logic [LARGURA-1:0] r_contagem;

    // Load wins over counting; counting halts once zero is reached.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (i_carga) begin
            r_contagem <= i_valor;
        end else if (i_habilita && (r_contagem != '0)) begin
            r_contagem <= r_contagem - 1'b1;
        end
    end

    assign o_zero = (r_contagem == '0);

endmodule

// File: rtl/apresentador_sequencia.sv
// Plays the stored sequence on the LEDs: fetch each ROM word, show it lit,
// then blank, and pulse pronto after address lim_r.
module apresentador_sequencia
    import jogo_pkg::*;
#(
    parameter int unsigned T_ACESO   = T_ACESO_PADRAO,
    parameter int unsigned T_APAGADO = T_APAGADO_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset,
    apresentador_sequencia_if.slave  bus
);

    localparam int unsigned LARGURA = largura_temporizador(T_ACESO, T_APAGADO);
    localparam logic [LARGURA-1:0] RECARGA_ACESO   = LARGURA'(T_ACESO - 1);
    localparam logic [LARGURA-1:0] RECARGA_APAGADO = LARGURA'(T_APAGADO - 1);

    estado_apresentador_t r_estado;
    logic [3:0]           r_lim;
    logic [3:0]           r_endereco;
    logic [6:0]           r_leds;
    logic                 r_ocupado;
    logic                 r_pronto;

    logic                 w_carga;
    logic [LARGURA-1:0]   w_valor;
    logic                 w_habilita;
    logic                 w_zero;

    // One timer serves both lit and blank phases; it is reloaded on entry to each.
    always_comb begin
        w_carga = 1'b0;
        w_valor = '0;
        if (!bus.abortar) begin
            if (r_estado == CARREGA) begin
                w_carga = 1'b1;
                w_valor = RECARGA_ACESO;
            end else if ((r_estado == ACESO) && w_zero) begin
                w_carga = 1'b1;
                w_valor = RECARGA_APAGADO;
            end
        end
        w_habilita = (r_estado == ACESO) || (r_estado == APAGADO);
    end

    temporizador_carga #(
        .LARGURA (LARGURA)
    ) u_temporizador (
        .clock      (clock),
        .reset      (reset),
        .i_carga    (w_carga),
        .i_valor    (w_valor),
        .i_habilita (w_habilita),
        .o_zero     (w_zero)
    );

    // Playback FSM with registered outputs; abort beats every transition but reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_lim      <= '0;
            r_endereco <= '0;
            r_leds     <= '0;
            r_ocupado  <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            if ((r_estado != OCIOSO) && bus.abortar) begin
                r_estado  <= OCIOSO;
                r_leds    <= '0;
                r_ocupado <= 1'b0;
            end else begin
                case (r_estado)
                    OCIOSO: begin
                        r_leds <= '0;
                        if (bus.iniciar && !bus.abortar) begin
                            r_lim      <= bus.limite;
                            r_endereco <= '0;
                            r_ocupado  <= 1'b1;
                            r_estado   <= BUSCA;
                        end
                    end
                    BUSCA: begin
                        r_estado <= CARREGA;
                    end
                    CARREGA: begin
                        r_leds   <= bus.dado;
                        r_estado <= ACESO;
                    end
                    ACESO: begin
                        if (w_zero) begin
                            r_leds   <= '0;
                            r_estado <= APAGADO;
                        end
                    end
                    APAGADO: begin
                        // Stop test precedes the increment so the address never wraps.
                        if (w_zero) begin
                            if (r_endereco == r_lim) begin
                                r_pronto <= 1'b1;
                                r_estado <= FIM;
                            end else begin
                                r_endereco <= r_endereco + 4'd1;
                                r_estado   <= BUSCA;
                            end
                        end
                    end
                    FIM: begin
                        r_ocupado <= 1'b0;
                        r_estado  <= OCIOSO;
                    end
                    default: begin
                        r_leds    <= '0;
                        r_ocupado <= 1'b0;
                        r_estado  <= OCIOSO;
                    end
                endcase
            end
        end
    end

    assign bus.endereco  = r_endereco;
    assign bus.leds      = r_leds;
    assign bus.ocupado   = r_ocupado;
    assign bus.pronto    = r_pronto;
    assign bus.db_estado = r_estado;

endmodule
